// File: rtl/cpu_shot_if.sv
// Shot request, board snapshot and result bus between the game controller and the CPU shooter.
interface cpu_shot_if;
  logic                 start;
  logic                 fixed_en;
  logic [2:0]           fixed_x;
  logic [2:0]           fixed_y;
  logic [4:0][4:0][2:0] board_in;
  logic [4:0][4:0][2:0] board_out;
  logic [2:0]           shot_x;
  logic [2:0]           shot_y;
  logic                 hit;
  logic                 sunk;
  logic [2:0]           sunk_id;
  logic                 game_over;
  logic                 no_target;
  logic                 busy;
  logic                 done;

  modport master (
    output start, fixed_en, fixed_x, fixed_y, board_in,
    input  board_out, shot_x, shot_y, hit, sunk, sunk_id, game_over, no_target, busy, done
  );

  modport slave (
    input  start, fixed_en, fixed_x, fixed_y, board_in,
    output board_out, shot_x, shot_y, hit, sunk, sunk_id, game_over, no_target, busy, done
  );
endinterface

// File: rtl/cpu_shot.sv
// CPU opponent shot: snapshot board, pick an unfired cell from LFSR/override, mark hit/miss, report sunk/game over.
// Latency start->done is 4+k cycles (k skipped cells, 27 when exhausted); start while busy is dropped, not queued.
module cpu_shot #(
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic     clk,
  input  logic     rst,
  cpu_shot_if.slave s
);

  typedef enum logic [2:0] {IDLE, LOAD, PROBE, WRITE, EVAL, DONE} state_t;

  state_t               r_state;
  logic [7:0]           r_lfsr;
  logic [4:0][4:0][2:0] r_board;
  logic [2:0]           r_cx;
  logic [2:0]           r_cy;
  logic [4:0]           r_cnt;
  logic [2:0]           r_id;
  logic [2:0]           r_shot_x;
  logic [2:0]           r_shot_y;
  logic                 r_hit;
  logic                 r_sunk;
  logic [2:0]           r_sunk_id;
  logic                 r_game_over;
  logic                 r_no_target;
  logic                 r_busy;
  logic                 r_done;

  logic [2:0]           w_cell;
  logic                 w_id_left;
  logic                 w_ship_left;

  function automatic logic [2:0] reduce5(input logic [2:0] v);
    return (v >= 3'd5) ? v - 3'd5 : v;
  endfunction

  assign w_cell = r_board[r_cx][r_cy];

  always_comb begin
    w_id_left   = 1'b0;
    w_ship_left = 1'b0;
    for (int x = 0; x < 5; x++) begin
      for (int y = 0; y < 5; y++) begin
        if (r_board[x][y] == r_id) w_id_left = 1'b1;
        if (r_board[x][y] >= 3'd1 && r_board[x][y] <= 3'd5) w_ship_left = 1'b1;
      end
    end
  end

  // Free-running Fibonacci LFSR, taps 8,6,5,4
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_lfsr <= LFSR_SEED;
    else     r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_board     <= '0;
      r_cx        <= '0;
      r_cy        <= '0;
      r_cnt       <= '0;
      r_id        <= '0;
      r_shot_x    <= '0;
      r_shot_y    <= '0;
      r_hit       <= 1'b0;
      r_sunk      <= 1'b0;
      r_sunk_id   <= '0;
      r_game_over <= 1'b0;
      r_no_target <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (s.start) begin
            // Board and candidate are both taken at the start edge
            r_board <= s.board_in;
            r_cx    <= reduce5(s.fixed_en ? s.fixed_x : r_lfsr[2:0]);
            r_cy    <= reduce5(s.fixed_en ? s.fixed_y : r_lfsr[5:3]);
            r_busy  <= 1'b1;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          r_cnt       <= '0;
          r_hit       <= 1'b0;
          r_sunk      <= 1'b0;
          r_sunk_id   <= '0;
          r_game_over <= 1'b0;
          r_no_target <= 1'b0;
          r_state     <= PROBE;
        end
        PROBE: begin
          if (r_cnt == 5'd25) begin
            r_no_target <= 1'b1;
            r_done      <= 1'b1;
            r_state     <= DONE;
          end else if (w_cell <= 3'd5) begin
            r_state <= WRITE;
          end else begin
            r_cnt <= r_cnt + 5'd1;
            if (r_cy == 3'd4) begin
              r_cy <= 3'd0;
              r_cx <= (r_cx == 3'd4) ? 3'd0 : r_cx + 3'd1;
            end else begin
              r_cy <= r_cy + 3'd1;
            end
          end
        end
        WRITE: begin
          r_board[r_cx][r_cy] <= (w_cell == 3'd0) ? 3'd7 : 3'd6;
          r_hit               <= (w_cell != 3'd0);
          r_id                <= w_cell;
          r_shot_x            <= r_cx;
          r_shot_y            <= r_cy;
          r_state             <= EVAL;
        end
        EVAL: begin
          r_sunk      <= r_hit && !w_id_left;
          r_sunk_id   <= (r_hit && !w_id_left) ? r_id : 3'd0;
          r_game_over <= !w_ship_left;
          r_done      <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s.board_out = r_board;
  assign s.shot_x    = r_shot_x;
  assign s.shot_y    = r_shot_y;
  assign s.hit       = r_hit;
  assign s.sunk      = r_sunk;
  assign s.sunk_id   = r_sunk_id;
  assign s.game_over = r_game_over;
  assign s.no_target = r_no_target;
  assign s.busy      = r_busy;
  assign s.done      = r_done;

endmodule

// File: doc/cpu_shot.md
Name: cpu_shot

Overview:
- Computer-opponent shooter for the 5x5 battleship game; the counterpart of the human player's shot block.
- On `start` it snapshots the player's board and picks a target cell not yet fired at. The target comes from an LFSR, or from a fixed override for test.
- It marks the cell hit (6) or miss (7), reports sunk and game-over status, and returns the updated board to the game controller.
- Cell encoding: 0 water, 1-5 ship id, 6 hit, 7 miss.

Parameters:
- LFSR_SEED, 8'hA5, reset value of the 8-bit Fibonacci LFSR (taps 8,6,5,4); must be non-zero.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  one-cycle request to take a shot; ignored while busy.
- fixed_en  in  1  when 1 at start, the candidate comes from fixed_x/fixed_y instead of the LFSR.
- fixed_x  in  3  override row.
- fixed_y  in  3  override column.
- board_in  in  3 x [4:0][4:0]  player board; sampled only at start.
- board_out  out  3 x [4:0][4:0]  internal board copy, driven continuously.
- shot_x  out  3  row actually fired at; valid with done.
- shot_y  out  3  column actually fired at; valid with done.
- hit  out  1  the shot struck a ship.
- sunk  out  1  the hit removed the last remaining cell of that ship id.
- sunk_id  out  3  id of the sunk ship; 0 when sunk=0.
- game_over  out  1  no cell holds 1-5 after the shot.
- no_target  out  1  all 25 cells were already 6/7; no write performed.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; result outputs valid.

Behaviour:
- Reset (async, any state):
  - State goes to IDLE; LFSR loads LFSR_SEED.
  - Board copy cleared to 0; all outputs 0.
  - Reset mid-shot abandons the shot with no done pulse.
- LFSR: advances every clock after reset, free-running regardless of state.
- Coordinate reduction: any 3-bit value v >= 5 maps to v-5. This applies to both fixed_* and LFSR-derived values.
  - Candidate x = reduce(lfsr[2:0]); candidate y = reduce(lfsr[5:3]).
- FSM states: IDLE, LOAD, PROBE, WRITE, EVAL, DONE.
- IDLE:
  - On start=1, go to LOAD.
  - Result outputs hold their last values until the next start.
- LOAD (1 cycle):
  - Copy board_in into the board copy.
  - Latch the candidate (fixed or LFSR, taken at the start edge).
  - Clear the probe counter (5-bit) and all result flags. Go to PROBE.
- PROBE (1 cycle per probed cell):
  - If cell[cx][cy] is 0-5, go to WRITE.
  - Else increment the probe counter and advance the scan: y+1; on y=4 wrap to y=0 and x+1; (4,4) wraps to (0,0).
  - When the counter reaches 25, set no_target=1 and go to DONE.
- WRITE (1 cycle):
  - Cell 0: write 7, hit=0.
  - Cell 1-5: write 6, hit=1, and latch the struck id.
  - Latch shot_x/shot_y. Go to EVAL.
- EVAL (1 cycle), computed combinationally over the updated copy:
  - sunk = hit AND no cell equals the latched id; sunk_id = id if sunk, else 0.
  - game_over = no cell holds a value in 1-5.
  - Go to DONE.
- DONE (1 cycle): done=1, then return to IDLE.
- Latency:
  - start sampled at edge t0; done is high in the cycle after edge t0+4+k, where k is the number of skipped cells.
  - Maximum latency is with k=24.
  - The no_target case asserts done after edge t0+27 (LOAD + 25 probes + DONE).
- Only the single written cell differs between board_in and board_out; ship ids are never altered except by 6.
- start asserted while busy is dropped, not queued.
- done and start in the same cycle: the start is ignored (busy still high in DONE).

Test Plan:
- Miss: board all 0, fixed_en=1, fixed=(2,3), start → done after 4 edges; shot=(2,3), hit=0, board_out[2][3]=7, other cells 0, sunk=0, game_over=1.
- Hit, not sunk: ship 2 at (1,1),(1,2); fixed=(1,1) → hit=1, board_out[1][1]=6, sunk=0, sunk_id=0, game_over=0.
- Sunk and game over: (1,1)=6, (1,2)=2, no other ships; fixed=(1,2) → hit=1, sunk=1, sunk_id=2, game_over=1.
- Skip and wrap: (4,4)=7, (0,0)=6, (0,1)=0; fixed=(4,4) → k=2, shot=(0,1), hit=0, done 2 cycles later than the miss case; fixed=(7,7) reduces to (2,2).
- Exhausted: all cells 6/7 → no_target=1, done after edge t0+27, board_out equals board_in; start during busy produces no second done.
- Reset mid-PROBE → busy=0, board_out all 0, no done; after release with fixed_en=0, the first candidate matches the LFSR sequence from LFSR_SEED.
